muldiv_sequencer: RTL

Iterative HI/LO multiply/divide unit with its own sequencing FSM for the pipelined MIPS CPU. Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-step shift-add or shift-subtract loop. Raises a stall request to the hazard/stall logic whenever a HI/LO access or a new mult/div arrives while an operation is in flight. Owns the architectural HI and LO registers.

---
 rtl/muldiv_sequencer_pkg.sv | 18 +
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: opcodes, FSM states
// and the default datapath width.
package muldiv_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative unit: shift-add multiply on {acc, oper} or
// restoring shift-subtract divide on {acc, oper}, chosen by is_div.
module muldiv_step
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] oper,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] oper_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic           fits;

   // The trial remainder is always below m after a successful subtract, so the
   // low WIDTH bits of the difference are exact.
   always_comb begin
      sum       = {1'b0, acc} + ({(WIDTH+1){oper[0]}} & {1'b0, m});
      shifted   = {acc, oper[WIDTH-1]};
      fits      = (shifted >= {1'b0, m});
      acc_next  = sum[WIDTH:1];
      oper_next = {sum[0], oper[WIDTH-1:1]};
      if (is_div) begin
         acc_next  = fits ? (shifted[WIDTH-1:0] - m) : shifted[WIDTH-1:0];
         oper_next = {oper[WIDTH-2:0], fits};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: magnitudes are iterated for
// WIDTH cycles, then signs are fixed up and HI/LO written in one extra cycle.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hilo_read,
   input  logic             hi_write,
   input  logic             lo_write,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc, oper, operand_b;
   logic             is_div, neg_main, neg_rem, div_zero;
   logic             signed_op, div_op, accept;
   logic [WIDTH-1:0] rs_abs, rt_abs;
   logic [WIDTH-1:0] step_acc, step_oper;
   logic [2*WIDTH-1:0] product, product_fix;
   logic [WIDTH-1:0] res_hi, res_lo;

   assign busy      = (state != ST_IDLE);
   assign stall_req = busy & (hilo_read | hi_write | lo_write | start);
   // An MTHI/MTLO in the same EX slot as a start means the start is bogus.
   assign accept    = (state == ST_IDLE) & start & ~hi_write & ~lo_write;

   always_comb begin
      signed_op = 1'b0;
      div_op    = 1'b0;
      case (op)
         OP_MULT:  signed_op = 1'b1;
         OP_MULTU: signed_op = 1'b0;
         OP_DIV: begin
            signed_op = 1'b1;
            div_op    = 1'b1;
         end
         OP_DIVU:  div_op = 1'b1;
         default:  signed_op = 1'b0;
      endcase
      rs_abs = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
      rt_abs = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div    (is_div),
      .acc       (acc),
      .oper      (oper),
      .m         (operand_b),
      .acc_next  (step_acc),
      .oper_next (step_oper)
   );

   // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient
   // while the remainder correction naturally restores the original dividend.
   always_comb begin
      product     = {acc, oper};
      product_fix = neg_main ? -product : product;
      res_hi      = product_fix[2*WIDTH-1:WIDTH];
      res_lo      = product_fix[WIDTH-1:0];
      if (is_div) begin
         res_lo = div_zero ? {WIDTH{1'b1}} : (neg_main ? -oper : oper);
         res_hi = neg_rem ? -acc : acc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_RUN;
         ST_RUN:  if (count == CW'(WIDTH - 1)) state_next = ST_FIX;
         ST_FIX:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         acc       <= '0;
         oper      <= '0;
         operand_b <= '0;
         is_div    <= 1'b0;
         neg_main  <= 1'b0;
         neg_rem   <= 1'b0;
         div_zero  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  count     <= '0;
                  acc       <= '0;
                  oper      <= rs_abs;
                  operand_b <= rt_abs;
                  is_div    <= div_op;
                  neg_main  <= signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_rem   <= signed_op & rs_val[WIDTH-1];
                  div_zero  <= div_op & (rt_val == '0);
               end else begin
                  if (hi_write) hi <= wdata;
                  if (lo_write) lo <= wdata;
               end
            end
            ST_RUN: begin
               acc   <= step_acc;
               oper  <= step_oper;
               count <= count + 1'b1;
            end
            ST_FIX: begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
            end
            default: done <= 1'b0;
         endcase
      end
   end

endmodule
